// File: rtl/mm_round_sequencer_pkg.sv
// Shared types and constants for the Mastermind round sequencer.
// Peg counts, index widths and the sequencer state encoding live here.
package mm_pkg;

    localparam int NUM_PEGS = 4;
    localparam int PEG_W    = 3;
    localparam int IDX_W    = 2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PEGS - 1);
    localparam logic [PEG_W-1:0] ALL_RED  = PEG_W'(NUM_PEGS);

    typedef enum logic [2:0] {
        CODE_ENTRY,
        GUESS_ENTRY,
        CLEAR,
        SWEEP,
        SETTLE,
        EVAL,
        WIN,
        LOSE
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == CLEAR) || (s == SWEEP) || (s == SETTLE) || (s == EVAL);
    endfunction

endpackage

// File: rtl/mm_round_sequencer_if.sv
// Board/datapath bundle of the round sequencer; the board side is the master,
// the sequencer is the slave.
interface mm_round_sequencer_if;

    logic                     load_btn;
    logic                     new_game;
    logic [mm_pkg::PEG_W-1:0] red_in;
    logic [mm_pkg::PEG_W-1:0] white_in;
    logic                     code_we;
    logic                     guess_we;
    logic [mm_pkg::IDX_W-1:0] digit_idx;
    logic                     clr_score;
    logic                     cmp_en;
    logic [mm_pkg::IDX_W-1:0] cmp_idx;
    logic [3:0]               round;
    logic [mm_pkg::PEG_W-1:0] last_red;
    logic [mm_pkg::PEG_W-1:0] last_white;
    logic                     result_valid;
    logic                     win;
    logic                     lose;
    logic                     busy;

    modport master (
        output load_btn, new_game, red_in, white_in,
        input  code_we, guess_we, digit_idx, clr_score, cmp_en, cmp_idx,
               round, last_red, last_white, result_valid, win, lose, busy
    );

    modport slave (
        input  load_btn, new_game, red_in, white_in,
        output code_we, guess_we, digit_idx, clr_score, cmp_en, cmp_idx,
               round, last_red, last_white, result_valid, win, lose, busy
    );

endinterface

// File: rtl/mm_round_sequencer_press_detect.sv
// Rising-edge detector for the already-synchronised load button,
// so a held button produces exactly one action.
module mm_press_detect (
    input  logic clk,
    input  logic resetn,
    input  logic load_btn,
    output logic load_rise
);

    logic load_q;

    always_ff @(posedge clk) begin
        if (!resetn)
            load_q <= 1'b0;
        else
            load_q <= load_btn;
    end

    assign load_rise = resetn & load_btn & ~load_q;

endmodule

// File: rtl/mm_round_sequencer.sv
// Game-level sequencer: digit entry strobes, clear + compare sweep,
// result sampling and WIN/LOSE tracking for one Mastermind game.
module mm_round_sequencer
    import mm_pkg::*;
#(
    parameter int MAX_GUESSES   = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input logic                 clk,
    input logic                 resetn,
    mm_round_sequencer_if.slave bus
);

    localparam logic [3:0] ROUND_LIMIT = 4'(MAX_GUESSES);
    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [IDX_W-1:0] digit_idx;
    logic [IDX_W-1:0] sweep_cnt;
    logic [1:0]       settle_cnt;
    logic [3:0]       round;
    logic [PEG_W-1:0] last_red;
    logic [PEG_W-1:0] last_white;
    logic             result_valid;
    logic             load_rise;

    mm_press_detect u_press (
        .clk       (clk),
        .resetn    (resetn),
        .load_btn  (bus.load_btn),
        .load_rise (load_rise)
    );

    // new_game overrides every state; EVAL cannot recur once round hits the limit.
    always_ff @(posedge clk) begin
        result_valid <= 1'b0;
        if (!resetn) begin
            state      <= CODE_ENTRY;
            digit_idx  <= '0;
            sweep_cnt  <= '0;
            settle_cnt <= '0;
            round      <= '0;
            last_red   <= '0;
            last_white <= '0;
        end else if (bus.new_game) begin
            state      <= CODE_ENTRY;
            digit_idx  <= '0;
            sweep_cnt  <= '0;
            settle_cnt <= '0;
            round      <= '0;
            last_red   <= '0;
            last_white <= '0;
        end else begin
            case (state)
                CODE_ENTRY: begin
                    if (load_rise) begin
                        digit_idx <= digit_idx + 1'b1;
                        if (digit_idx == LAST_IDX)
                            state <= GUESS_ENTRY;
                    end
                end
                GUESS_ENTRY: begin
                    if (load_rise) begin
                        digit_idx <= digit_idx + 1'b1;
                        if (digit_idx == LAST_IDX)
                            state <= CLEAR;
                    end
                end
                CLEAR: begin
                    state     <= SWEEP;
                    sweep_cnt <= '0;
                end
                SWEEP: begin
                    if (sweep_cnt == LAST_IDX) begin
                        state      <= SETTLE;
                        sweep_cnt  <= '0;
                        settle_cnt <= '0;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state      <= EVAL;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                EVAL: begin
                    last_red     <= bus.red_in;
                    last_white   <= bus.white_in;
                    round        <= round + 4'd1;
                    result_valid <= 1'b1;
                    if (bus.red_in == ALL_RED)
                        state <= WIN;
                    else if (round + 4'd1 == ROUND_LIMIT)
                        state <= LOSE;
                    else
                        state <= GUESS_ENTRY;
                end
                WIN:     state <= WIN;
                LOSE:    state <= LOSE;
                default: state <= CODE_ENTRY;
            endcase
        end
    end

    assign bus.code_we      = load_rise & (state == CODE_ENTRY) & ~bus.new_game;
    assign bus.guess_we     = load_rise & (state == GUESS_ENTRY) & ~bus.new_game;
    assign bus.clr_score    = resetn & ((state == CLEAR) | bus.new_game);
    assign bus.cmp_en       = (state == SWEEP);
    assign bus.cmp_idx      = (state == SWEEP) ? sweep_cnt : '0;
    assign bus.digit_idx    = digit_idx;
    assign bus.round        = round;
    assign bus.last_red     = last_red;
    assign bus.last_white   = last_white;
    assign bus.result_valid = result_valid;
    assign bus.win          = (state == WIN);
    assign bus.lose         = (state == LOSE);
    assign bus.busy         = is_busy(state);

endmodule

// File: tb/tb_mm_round_sequencer.sv
// Directed bench for mm_round_sequencer: instance a uses MAX_GUESSES=8,
// instance b uses MAX_GUESSES=2 for the lose / last-guess-win cases.
module tb_mm_round_sequencer;

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_fail;

    mm_round_sequencer_if ifa ();
    mm_round_sequencer_if ifb ();

    mm_round_sequencer #(.MAX_GUESSES(8), .SETTLE_CYCLES(1)) dut_a (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifa)
    );

    mm_round_sequencer #(.MAX_GUESSES(2), .SETTLE_CYCLES(1)) dut_b (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each cycle begins 1 time unit after the rising edge; inputs are driven and outputs sampled there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit sel, output logic cw, output logic gw, output logic [1:0] di);
        step();
        if (sel) ifb.load_btn = 1'b1; else ifa.load_btn = 1'b1;
        #1;
        cw = sel ? ifb.code_we  : ifa.code_we;
        gw = sel ? ifb.guess_we : ifa.guess_we;
        di = sel ? ifb.digit_idx : ifa.digit_idx;
        step();
        if (sel) ifb.load_btn = 1'b0; else ifa.load_btn = 1'b0;
    endtask

    task automatic enter(input bit sel, input int n);
        logic cw, gw;
        logic [1:0] di;
        for (int i = 0; i < n; i++) press(sel, cw, gw, di);
    endtask

    task automatic pulse_new_game(input bit sel);
        step();
        if (sel) ifb.new_game = 1'b1; else ifa.new_game = 1'b1;
        step();
        if (sel) ifb.new_game = 1'b0; else ifa.new_game = 1'b0;
    endtask

    task automatic wait_result(input bit sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            if ((sel ? ifb.result_valid : ifa.result_valid) === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step();
        step();
        n_cmp++; if (ifa.digit_idx !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_digit_idx: got %0d expected 0", ifa.digit_idx); end
        n_cmp++; if (ifa.round !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_round: got %0d expected 0", ifa.round); end
        n_cmp++; if ({ifa.last_red, ifa.last_white} !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_last: got %0d/%0d expected 0/0", ifa.last_red, ifa.last_white); end
        n_cmp++; if ({ifa.busy, ifa.win, ifa.lose, ifa.result_valid} !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 0000", {ifa.busy, ifa.win, ifa.lose, ifa.result_valid}); end
        n_cmp++; if ({ifa.code_we, ifa.guess_we, ifa.clr_score, ifa.cmp_en} !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {ifa.code_we, ifa.guess_we, ifa.clr_score, ifa.cmp_en}); end
        n_cmp++; if ({ifb.busy, ifb.win, ifb.lose, ifb.round} !== 7'd0) begin n_fail++; $display("[TB] FAIL reset_b: got %b expected 0", {ifb.busy, ifb.win, ifb.lose, ifb.round}); end
        resetn = 1'b1;
    endtask

    task automatic test_hold();
        step();
        ifa.load_btn = 1'b1;
        #1;
        n_cmp++; if (ifa.code_we !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_first_strobe: got %b expected 1", ifa.code_we); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (ifa.code_we !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_repeat_%0d: got %b expected 0", i, ifa.code_we); end
        end
        n_cmp++; if (ifa.digit_idx !== 2'd1) begin n_fail++; $display("[TB] FAIL hold_digit_idx: got %0d expected 1", ifa.digit_idx); end
        step();
        ifa.load_btn = 1'b0;
    endtask

    task automatic test_new_game_entry();
        step();
        ifa.new_game = 1'b1;
        ifa.load_btn = 1'b1;
        #1;
        n_cmp++; if (ifa.code_we !== 1'b0) begin n_fail++; $display("[TB] FAIL ng_suppress_code_we: got %b expected 0", ifa.code_we); end
        n_cmp++; if (ifa.clr_score !== 1'b1) begin n_fail++; $display("[TB] FAIL ng_clr_score: got %b expected 1", ifa.clr_score); end
        step();
        ifa.new_game = 1'b0;
        ifa.load_btn = 1'b0;
        n_cmp++; if (ifa.digit_idx !== 2'd0) begin n_fail++; $display("[TB] FAIL ng_digit_idx: got %0d expected 0", ifa.digit_idx); end
    endtask

    task automatic test_round();
        logic cw, gw;
        logic [1:0] di;
        ifa.red_in   = 3'd2;
        ifa.white_in = 3'd1;
        for (int i = 0; i < 4; i++) begin
            press(1'b0, cw, gw, di);
            n_cmp++; if ({cw, gw, di} !== {2'b10, i[1:0]}) begin n_fail++; $display("[TB] FAIL code_press_%0d: got we=%b%b idx=%0d expected we=10 idx=%0d", i, cw, gw, di, i); end
        end
        for (int i = 0; i < 4; i++) begin
            press(1'b0, cw, gw, di);
            n_cmp++; if ({cw, gw, di} !== {2'b01, i[1:0]}) begin n_fail++; $display("[TB] FAIL guess_press_%0d: got we=%b%b idx=%0d expected we=01 idx=%0d", i, cw, gw, di, i); end
        end
        n_cmp++; if ({ifa.clr_score, ifa.busy, ifa.cmp_en} !== 3'b110) begin n_fail++; $display("[TB] FAIL clear_cycle: got clr/busy/cmp=%b expected 110", {ifa.clr_score, ifa.busy, ifa.cmp_en}); end
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++; if ({ifa.cmp_en, ifa.cmp_idx, ifa.clr_score} !== {1'b1, k[1:0], 1'b0}) begin n_fail++; $display("[TB] FAIL sweep_%0d: got en=%b idx=%0d clr=%b expected en=1 idx=%0d clr=0", k, ifa.cmp_en, ifa.cmp_idx, ifa.clr_score, k); end
        end
        step();
        n_cmp++; if ({ifa.cmp_en, ifa.cmp_idx, ifa.busy} !== 4'b0001) begin n_fail++; $display("[TB] FAIL settle_cycle: got en=%b idx=%0d busy=%b expected 0/0/1", ifa.cmp_en, ifa.cmp_idx, ifa.busy); end
        step();
        n_cmp++; if ({ifa.result_valid, ifa.busy, ifa.round} !== {2'b01, 4'd0}) begin n_fail++; $display("[TB] FAIL eval_cycle: got rv=%b busy=%b round=%0d expected 0/1/0", ifa.result_valid, ifa.busy, ifa.round); end
        step();
        n_cmp++; if (ifa.result_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL result_valid_latency: got %b expected 1", ifa.result_valid); end
        n_cmp++; if ({ifa.round, ifa.last_red, ifa.last_white} !== {4'd1, 3'd2, 3'd1}) begin n_fail++; $display("[TB] FAIL round1_values: got round=%0d red=%0d white=%0d expected 1/2/1", ifa.round, ifa.last_red, ifa.last_white); end
        step();
        n_cmp++; if ({ifa.result_valid, ifa.busy, ifa.win, ifa.lose} !== 4'b0000) begin n_fail++; $display("[TB] FAIL after_result: got %b expected 0000", {ifa.result_valid, ifa.busy, ifa.win, ifa.lose}); end
    endtask

    task automatic test_win();
        logic cw, gw;
        logic [1:0] di;
        bit ok;
        ifa.red_in   = 3'd4;
        ifa.white_in = 3'd0;
        enter(1'b0, 4);
        wait_result(1'b0, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL win_timeout: got no result_valid expected one within 30 cycles"); end
        n_cmp++; if ({ifa.win, ifa.lose, ifa.round, ifa.last_red} !== {2'b10, 4'd2, 3'd4}) begin n_fail++; $display("[TB] FAIL win_state: got win=%b lose=%b round=%0d red=%0d expected 1/0/2/4", ifa.win, ifa.lose, ifa.round, ifa.last_red); end
        press(1'b0, cw, gw, di);
        n_cmp++; if ({cw, gw} !== 2'b00) begin n_fail++; $display("[TB] FAIL win_press_ignored: got we=%b%b expected 00", cw, gw); end
        n_cmp++; if ({ifa.win, ifa.busy} !== 2'b10) begin n_fail++; $display("[TB] FAIL win_holds: got win=%b busy=%b expected 1/0", ifa.win, ifa.busy); end
    endtask

    task automatic test_lose();
        logic cw, gw;
        logic [1:0] di;
        bit ok;
        ifb.red_in   = 3'd1;
        ifb.white_in = 3'd2;
        enter(1'b1, 8);
        wait_result(1'b1, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL lose_r1_timeout: got no result_valid expected one within 30 cycles"); end
        n_cmp++; if ({ifb.last_red, ifb.last_white, ifb.round, ifb.win, ifb.lose} !== {3'd1, 3'd2, 4'd1, 2'b00}) begin n_fail++; $display("[TB] FAIL lose_r1_values: got red=%0d white=%0d round=%0d win=%b lose=%b expected 1/2/1/0/0", ifb.last_red, ifb.last_white, ifb.round, ifb.win, ifb.lose); end
        press(1'b1, cw, gw, di);
        n_cmp++; if ({cw, gw, di} !== {2'b01, 2'd0}) begin n_fail++; $display("[TB] FAIL lose_back_to_guess: got we=%b%b idx=%0d expected we=01 idx=0", cw, gw, di); end
        enter(1'b1, 3);
        wait_result(1'b1, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL lose_r2_timeout: got no result_valid expected one within 30 cycles"); end
        n_cmp++; if ({ifb.lose, ifb.win, ifb.round} !== {2'b10, 4'd2}) begin n_fail++; $display("[TB] FAIL lose_final: got lose=%b win=%b round=%0d expected 1/0/2", ifb.lose, ifb.win, ifb.round); end
        press(1'b1, cw, gw, di);
        n_cmp++; if ({cw, gw, ifb.lose} !== 3'b001) begin n_fail++; $display("[TB] FAIL lose_holds: got we=%b%b lose=%b expected 00/1", cw, gw, ifb.lose); end
    endtask

    task automatic test_final_win();
        bit ok;
        pulse_new_game(1'b1);
        n_cmp++; if ({ifb.lose, ifb.round} !== 5'd0) begin n_fail++; $display("[TB] FAIL fw_new_game: got lose=%b round=%0d expected 0/0", ifb.lose, ifb.round); end
        ifb.red_in   = 3'd1;
        ifb.white_in = 3'd2;
        enter(1'b1, 8);
        wait_result(1'b1, ok);
        ifb.red_in   = 3'd4;
        ifb.white_in = 3'd0;
        enter(1'b1, 4);
        wait_result(1'b1, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL fw_timeout: got no result_valid expected one within 30 cycles"); end
        n_cmp++; if ({ifb.win, ifb.lose, ifb.round} !== {2'b10, 4'd2}) begin n_fail++; $display("[TB] FAIL fw_priority: got win=%b lose=%b round=%0d expected 1/0/2", ifb.win, ifb.lose, ifb.round); end
    endtask

    task automatic run_to_sweep_idx2();
        bit ok;
        ifa.red_in   = 3'd1;
        ifa.white_in = 3'd0;
        enter(1'b0, 8);
        wait_result(1'b0, ok);
        n_cmp++; if (!ok || ifa.round !== 4'd1) begin n_fail++; $display("[TB] FAIL abort_setup: got ok=%b round=%0d expected 1/1", ok, ifa.round); end
        enter(1'b0, 4);
        step();
        step();
        step();
        n_cmp++; if ({ifa.cmp_en, ifa.cmp_idx} !== 3'b110) begin n_fail++; $display("[TB] FAIL abort_at_idx2: got en=%b idx=%0d expected 1/2", ifa.cmp_en, ifa.cmp_idx); end
    endtask

    task automatic test_new_game_sweep();
        pulse_new_game(1'b0);
        run_to_sweep_idx2();
        ifa.new_game = 1'b1;
        #1;
        n_cmp++; if (ifa.clr_score !== 1'b1) begin n_fail++; $display("[TB] FAIL ng_sweep_clr: got %b expected 1", ifa.clr_score); end
        step();
        ifa.new_game = 1'b0;
        n_cmp++; if ({ifa.cmp_en, ifa.busy, ifa.round, ifa.last_red, ifa.digit_idx} !== 11'd0) begin n_fail++; $display("[TB] FAIL ng_sweep_cleared: got en=%b busy=%b round=%0d red=%0d idx=%0d expected all 0", ifa.cmp_en, ifa.busy, ifa.round, ifa.last_red, ifa.digit_idx); end
    endtask

    task automatic test_reset_sweep();
        run_to_sweep_idx2();
        resetn = 1'b0;
        step();
        n_cmp++; if ({ifa.cmp_en, ifa.clr_score, ifa.busy, ifa.round, ifa.last_red, ifa.digit_idx} !== 12'd0) begin n_fail++; $display("[TB] FAIL rst_sweep_cleared: got en=%b clr=%b busy=%b round=%0d red=%0d idx=%0d expected all 0", ifa.cmp_en, ifa.clr_score, ifa.busy, ifa.round, ifa.last_red, ifa.digit_idx); end
        resetn = 1'b1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        resetn = 1'b0;
        ifa.load_btn = 1'b0; ifa.new_game = 1'b0; ifa.red_in = 3'd0; ifa.white_in = 3'd0;
        ifb.load_btn = 1'b0; ifb.new_game = 1'b0; ifb.red_in = 3'd0; ifb.white_in = 3'd0;
        test_reset();
        test_hold();
        test_new_game_entry();
        test_round();
        test_win();
        test_lose();
        test_final_win();
        test_new_game_sweep();
        test_reset_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
